// File: rtl/fine_cfo_estimate.sv
// Fine CFO estimator: lag-64 autocorrelation over the two LTF symbols, sequential CORDIC
// angle, divide by lag. Define FINE_CFO_MAG_OUT_EN to add the m_mag confidence output.
module fine_cfo_estimate #(
  parameter int unsigned DW           = 16,
  parameter int unsigned ACC_W        = 40,
  parameter int unsigned ANG_W        = 32,
  parameter int unsigned CORDIC_ITERS = 24,
  parameter int unsigned LAG_LOG2     = 6
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    s_start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [DW-1:0]    s_re,
  input  logic signed [DW-1:0]    s_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ANG_W-1:0] m_phase_inc,
`ifdef FINE_CFO_MAG_OUT_EN
  output logic signed [ACC_W+1:0] m_mag,
`endif
  output logic                    busy
);

  localparam int unsigned LAG    = 1 << LAG_LOG2;
  localparam int unsigned CNT_W  = LAG_LOG2 + 1;
  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned XY_W   = ACC_W + 2;
  localparam int unsigned IT_W   = $clog2(CORDIC_ITERS + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_CORR   = 3'd2;
  localparam logic [2:0] S_CORDIC = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  // +pi and -pi share one code modulo 2^ANG_W
  localparam logic signed [ANG_W-1:0] PI_ANG = {1'b1, {(ANG_W-1){1'b0}}};

  // atan(2^-i) with pi = 2^31, truncated, rescaled to ANG_W bits
  function automatic logic signed [ANG_W-1:0] atan_lut(input logic [IT_W-1:0] i);
    logic [31:0] v;
    case (int'(i))
      0:       v = 32'h2000_0000;
      1:       v = 32'h12E4_051D;
      2:       v = 32'h09FB_385B;
      3:       v = 32'h0511_11D4;
      4:       v = 32'h028B_0D43;
      5:       v = 32'h0145_D7E1;
      6:       v = 32'h00A2_F61E;
      7:       v = 32'h0051_7C55;
      8:       v = 32'h0028_BE53;
      9:       v = 32'h0014_5F2E;
      10:      v = 32'h000A_2F98;
      11:      v = 32'h0005_17CC;
      12:      v = 32'h0002_8BE6;
      13:      v = 32'h0001_45F3;
      14:      v = 32'h0000_A2F9;
      15:      v = 32'h0000_517C;
      16:      v = 32'h0000_28BE;
      17:      v = 32'h0000_145F;
      18:      v = 32'h0000_0A2F;
      19:      v = 32'h0000_0517;
      20:      v = 32'h0000_028B;
      21:      v = 32'h0000_0145;
      22:      v = 32'h0000_00A2;
      23:      v = 32'h0000_0051;
      24:      v = 32'h0000_0028;
      25:      v = 32'h0000_0014;
      26:      v = 32'h0000_000A;
      27:      v = 32'h0000_0005;
      28:      v = 32'h0000_0002;
      29:      v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return ANG_W'(v >> (32 - ANG_W));
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [XY_W-1:0] sext_acc(input logic signed [ACC_W-1:0] a);
    return {{(XY_W-ACC_W){a[ACC_W-1]}}, a};
  endfunction

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic signed [XY_W-1:0]   x_q, x_d;
  logic signed [XY_W-1:0]   y_q, y_d;
  logic signed [ANG_W-1:0]  z_q, z_d;
  logic                     z_hold_q, z_hold_d;
  logic [IT_W-1:0]          it_q, it_d;
  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic signed [ANG_W-1:0]  m_phase_q, m_phase_d;
  logic                     busy_q, busy_d;
`ifdef FINE_CFO_MAG_OUT_EN
  logic signed [XY_W-1:0]   mag_q, mag_d;
`endif

  logic s_fire;
  logic m_fire;
  assign s_fire = s_valid && s_ready_q;
  assign m_fire = m_valid_q && m_ready;

  // Delay line: pure storage, every entry is rewritten in FILL before CORR reads it
  logic signed [DW-1:0] dly_re_q [LAG];
  logic signed [DW-1:0] dly_im_q [LAG];
  logic                 dly_we;
  logic [LAG_LOG2-1:0]  dly_waddr;

  always_ff @(posedge ap_clk) begin
    if (dly_we) begin
      dly_re_q[dly_waddr] <= s_re;
      dly_im_q[dly_waddr] <= s_im;
    end
  end

  // Index n-64 shares the low address bits with n
  logic signed [DW-1:0] d_re, d_im;
  assign d_re = dly_re_q[cnt_q[LAG_LOG2-1:0]];
  assign d_im = dly_im_q[cnt_q[LAG_LOG2-1:0]];

  // s * conj(d) with full-width products
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [ACC_W-1:0]  corr_re, corr_im;
  assign p_rr    = PROD_W'(s_re) * PROD_W'(d_re);
  assign p_ii    = PROD_W'(s_im) * PROD_W'(d_im);
  assign p_ir    = PROD_W'(s_im) * PROD_W'(d_re);
  assign p_ri    = PROD_W'(s_re) * PROD_W'(d_im);
  assign corr_re = sext_prod(p_rr) + sext_prod(p_ii);
  assign corr_im = sext_prod(p_ir) - sext_prod(p_ri);

  // it_q = 0 is the pre-rotation, 1..CORDIC_ITERS are iterations, then output
  logic [IT_W-1:0]         iter_idx;
  logic signed [XY_W-1:0]  x_sh, y_sh;
  logic signed [ANG_W-1:0] atan_i;
  assign iter_idx = it_q - IT_W'(1);
  assign x_sh     = x_q >>> iter_idx;
  assign y_sh     = y_q >>> iter_idx;
  assign atan_i   = atan_lut(iter_idx);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    z_hold_d  = z_hold_q;
    it_d      = it_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_phase_d = m_phase_q;
`ifdef FINE_CFO_MAG_OUT_EN
    mag_d     = mag_q;
`endif
    dly_we    = 1'b0;
    dly_waddr = cnt_q[LAG_LOG2-1:0];

    case (state_q)
      S_IDLE: begin
        if (s_fire && s_start) begin
          dly_we    = 1'b1;
          dly_waddr = '0;
          cnt_d     = CNT_W'(1);
          state_d   = S_FILL;
        end
      end

      S_FILL, S_CORR: begin
        if (s_fire) begin
          if (s_start) begin
            // restart the burst: this sample becomes index 0
            dly_we    = 1'b1;
            dly_waddr = '0;
            cnt_d     = CNT_W'(1);
            acc_re_d  = '0;
            acc_im_d  = '0;
            state_d   = S_FILL;
          end else if (state_q == S_FILL) begin
            dly_we = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LAG - 1)) state_d = S_CORR;
          end else begin
            acc_re_d = acc_re_q + corr_re;
            acc_im_d = acc_im_q + corr_im;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(2 * LAG - 1)) begin
              state_d   = S_CORDIC;
              s_ready_d = 1'b0;
              it_d      = '0;
            end
          end
        end
      end

      S_CORDIC: begin
        it_d = it_q + IT_W'(1);
        if (it_q == '0) begin
          // fold the left half-plane onto the right; exact angles need no iterations
          if (acc_re_q[ACC_W-1]) begin
            x_d = -sext_acc(acc_re_q);
            y_d = -sext_acc(acc_im_q);
            z_d = PI_ANG;
          end else begin
            x_d = sext_acc(acc_re_q);
            y_d = sext_acc(acc_im_q);
            z_d = '0;
          end
          z_hold_d = (acc_im_q == '0);
        end else if (it_q == IT_W'(CORDIC_ITERS + 1)) begin
          m_valid_d = 1'b1;
          m_phase_d = z_q >>> LAG_LOG2;
`ifdef FINE_CFO_MAG_OUT_EN
          mag_d     = x_q;
`endif
          state_d   = S_OUT;
        end else if (!y_q[XY_W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          if (!z_hold_q) z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          if (!z_hold_q) z_d = z_q - atan_i;
        end
      end

      S_OUT: begin
        if (m_fire) begin
          m_valid_d = 1'b0;
          acc_re_d  = '0;
          acc_im_d  = '0;
          s_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      z_hold_q  <= 1'b0;
      it_q      <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_phase_q <= '0;
      busy_q    <= 1'b0;
`ifdef FINE_CFO_MAG_OUT_EN
      mag_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      z_hold_q  <= z_hold_d;
      it_q      <= it_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_phase_q <= m_phase_d;
      busy_q    <= busy_d;
`ifdef FINE_CFO_MAG_OUT_EN
      mag_q     <= mag_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_phase_inc = m_phase_q;
  assign busy        = busy_q;
`ifdef FINE_CFO_MAG_OUT_EN
  assign m_mag       = mag_q;
`endif

endmodule
